// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the serial-operand ALU.
package alu_pkg;

    localparam int unsigned OP_WIDTH = 2;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = 2'b00;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 2'b01;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 2'b10;
    localparam logic [OP_WIDTH-1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT_B = 2'b01,
        ST_EXEC   = 2'b10
    } state_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational datapath: evaluates op on zero-extended operands.
// Ports:
//   a, b       operands (DATA_WIDTH)
//   op         operation select {op[1], op[0]}
//   ext_result DATA_WIDTH+1 result; the top bit is carry/borrow/constant
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [DATA_WIDTH:0]   ext_result
);

    localparam int unsigned EXT_WIDTH = DATA_WIDTH + 1;

    logic [DATA_WIDTH:0] a_ext;
    logic [DATA_WIDTH:0] b_ext;

    assign a_ext = EXT_WIDTH'(a);
    assign b_ext = EXT_WIDTH'(b);

    // Extended-width evaluation: the zero top bits make XOR give 0 and XNOR give 1.
    always_comb begin
        ext_result = '0;
        case (op)
            OP_ADD:  ext_result = a_ext + b_ext;
            OP_SUB:  ext_result = a_ext - b_ext;
            OP_XOR:  ext_result = a_ext ^ b_ext;
            OP_XNOR: ext_result = ~(a_ext ^ b_ext);
            default: ext_result = '0;
        endcase
    end

endmodule : alu_core

// File: rtl/serial_op_alu.sv
// Two-beat serial ALU: beat 1 carries A and op[0], beat 2 carries B and op[1];
// one EXEC cycle later result/overflow load together with a one-cycle done.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   opcode_valid  qualifies opcode and data this cycle
//   opcode        one opcode bit per valid beat (op[0] first, then op[1])
//   data          operand A on the first beat, B on the second
//   result        registered low DATA_WIDTH bits of the extended result
//   overflow      registered bit DATA_WIDTH of the extended result
//   done          one-cycle pulse marking result/overflow update
module serial_op_alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  opcode_valid,
    input  logic                  opcode,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  overflow_d;
    logic                  done_d;
    logic [DATA_WIDTH:0]   ext_c;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .a          (a_q),
        .b          (b_q),
        .op         (op_q),
        .ext_result (ext_c)
    );

    // State, capture and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result   <= result_d;
            overflow <= overflow_d;
            done     <= done_d;
        end
    end

    // Next-state, capture and output-load logic; outputs hold unless leaving EXEC.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result;
        overflow_d = overflow;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (opcode_valid) begin
                    a_d     = data;
                    op_d[0] = opcode;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (opcode_valid) begin
                    b_d     = data;
                    op_d[1] = opcode;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Inputs are ignored here; a beat in this cycle is dropped.
                result_d   = ext_c[DATA_WIDTH-1:0];
                overflow_d = ext_c[DATA_WIDTH];
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule : serial_op_alu

// File: doc/serial_op_alu.md
Name: serial_op_alu

Overview:
- Two-operand ALU that feeds the ALU checker and its testbench. It is the design under test whose outputs the checker consumes.
- Operands and a 2-bit opcode arrive serially over two `opcode_valid` beats, one opcode bit per beat.
- The block computes the selected operation, then presents `result` and `overflow` together with a one-cycle `done` pulse.

Parameters:
- DATA_WIDTH, 8, width of each operand and of `result`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode_valid  input  1  qualifies `data` and `opcode` on this cycle.
- opcode  input  1  one opcode bit per valid beat; the first beat supplies op[0], the second supplies op[1].
- data  input  DATA_WIDTH  operand: the first beat is A, the second beat is B.
- result  output  DATA_WIDTH  registered result of the operation.
- overflow  output  1  registered bit DATA_WIDTH of the extended result.
- done  output  1  one-cycle pulse; `result` and `overflow` are valid in the same cycle.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset_n` is asynchronous, active-low. When `reset_n` is 0: `result`=0, `overflow`=0, `done`=0, state=IDLE, operand/opcode registers=0.
- States:
  - IDLE: waiting for A. On `opcode_valid`=1: capture A←`data`, op[0]←`opcode`, go to WAIT_B. Otherwise stay.
  - WAIT_B: waiting for B. On `opcode_valid`=1: capture B←`data`, op[1]←`opcode`, go to EXEC. Otherwise stay, with no timeout; any number of idle cycles between beats is legal.
  - EXEC: lasts exactly one cycle. `opcode_valid` is ignored here, with no capture and no error. At the edge leaving EXEC: load `result` and `overflow`, set `done`=1, go to IDLE.
- `done`:
  - Deasserts at the next edge.
  - Latency: B is captured at edge k, `done`=1 from edge k+1 to edge k+2. This is always within 2 cycles of the second capture.
- Back-to-back operations: `opcode_valid` in the `done` cycle (state IDLE) is captured as the next A.
- Opcode encoding, {op[1],op[0]}:
  - 00: ADD
  - 01: SUB, computed as A−B
  - 10: XOR
  - 11: XNOR
- Arithmetic: zero-extend A and B to DATA_WIDTH+1 bits and evaluate the operation at that width. `result` = bits [DATA_WIDTH-1:0]; `overflow` = bit DATA_WIDTH.
  - ADD: `overflow` = carry-out.
  - SUB: `overflow` = 1 iff A<B (borrow); wrap-around is modulo 2^DATA_WIDTH.
  - XOR: `overflow` is always 0.
  - XNOR: `overflow` is always 1, because the extended zero bits XNOR to 1.
- Output hold: `result` and `overflow` hold their last values between `done` pulses. They change only at the EXEC→IDLE edge or on reset.
- Reset mid-operation: a partially captured A, or the EXEC state, is discarded. The next two valid beats after reset release form a fresh operation.
- No X/Z checking on inputs.

Decomposition:
- Package `alu_pkg`:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_XOR=2'b10, OP_XNOR=2'b11;
  - state encodings ST_IDLE, ST_WAIT_B, ST_EXEC.
- Sub-module `alu_core`: combinational. Inputs A, B, op[1:0]; output a DATA_WIDTH+1 extended result. The top level holds the FSM, the capture registers and the output registers.

Test Plan:
- ADD: A=0xF0 with opcode=0, next cycle B=0x20 with opcode=0 → `done`=1 one cycle after the B edge, `result`=0x10, `overflow`=1, `done` low the following cycle.
- SUB: A=0x05 with opcode=1, B=0x07 with opcode=0 → `result`=0xFE, `overflow`=1. Then A=0x07, B=0x05 → `result`=0x02, `overflow`=0.
- XOR and XNOR with A=0xAA, B=0x0F:
  - op bits 0,1 → `result`=0xA5, `overflow`=0;
  - op bits 1,1 → `result`=0x5A, `overflow`=1.
- Gaps and EXEC input: 3 idle cycles between A and B, plus `opcode_valid`=1 with `data`=0x33 during EXEC → `result` unaffected. The next operation starts only from the following valid beat (or from a valid beat in the `done` cycle).
- Reset mid-operation: A=0x11 captured, then `reset_n` pulsed low between clock edges → all outputs 0 immediately. After release, A=0x01, B=0x02 with ADD → `result`=0x03, `overflow`=0.
- Back-to-back: a valid beat in the `done` cycle starts the next operation. Two operations complete with `done` pulses 3 cycles apart.
